// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB pipeline register, load extract/extend, register-file
// write port drive, retired-instruction counter and load-fault flag.
module wb_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        stall,
   input  logic        flush,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rd,
   input  logic [31:0] alu_result,
   input  logic [31:0] read_data,
   input  logic [31:0] pc_plus4,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        wb_valid,
   output logic        load_fault,
   output logic [63:0] instret
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   logic [1:0]  w_off;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   logic        w_bad_load;
   logic        w_fault;
   logic        w_writes;
   logic [31:0] w_wdata;
   logic        w_cap;
   logic        w_we_next;

   logic        r_valid;
   logic        r_we;
   logic        r_fault;
   logic [4:0]  r_waddr;
   logic [31:0] r_wdata;
   logic [63:0] r_instret;

   assign w_off  = alu_result[1:0];
   assign w_byte = read_data[8*w_off +: 8];
   assign w_half = w_off[1] ? read_data[31:16] : read_data[15:0];

   always_comb begin
      w_load_data = read_data;
      w_bad_load  = 1'b0;
      case (funct3)
         3'b000: w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b100: w_load_data = {24'h0, w_byte};
         3'b001: begin
            w_load_data = {{16{w_half[15]}}, w_half};
            w_bad_load  = w_off[0];
         end
         3'b101: begin
            w_load_data = {16'h0, w_half};
            w_bad_load  = w_off[0];
         end
         3'b010: w_bad_load = (w_off != 2'b00);
         default: w_bad_load = 1'b1;
      endcase
   end

   always_comb begin
      w_writes = 1'b1;
      w_wdata  = alu_result;
      case (opcode)
         OP_LOAD:                          w_wdata = w_load_data;
         OP_JAL, OP_JALR:                  w_wdata = pc_plus4;
         OP_REG, OP_IMM, OP_LUI, OP_AUIPC: w_wdata = alu_result;
         default:                          w_writes = 1'b0;
      endcase
   end

   assign w_fault   = (opcode == OP_LOAD) & w_bad_load;
   assign w_cap     = in_valid & ~flush;
   // Write enable is resolved before the register so rf_we is a clean flop output.
   assign w_we_next = w_cap & w_writes & ~w_fault & (rd != 5'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_we      <= 1'b0;
         r_fault   <= 1'b0;
         r_waddr   <= 5'd0;
         r_wdata   <= 32'd0;
         r_instret <= 64'd0;
      end else if (!stall) begin
         r_valid <= w_cap;
         r_we    <= w_we_next;
         r_fault <= w_cap & w_fault;
         r_waddr <= rd;
         r_wdata <= w_wdata;
         if (w_cap)
            r_instret <= r_instret + 64'd1;
      end else if (flush) begin
         // Flush beats stall: kill the held instruction, keep the data path and counter.
         r_valid <= 1'b0;
         r_we    <= 1'b0;
         r_fault <= 1'b0;
      end
   end

   assign rf_we      = r_we;
   assign rf_waddr   = r_waddr;
   assign rf_wdata   = r_wdata;
   assign wb_valid   = r_valid;
   assign load_fault = r_fault;
   assign instret    = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus random traffic against a
// behavioural model of the writeback rules.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, stall, flush;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [31:0] alu_result, read_data, pc_plus4;
   logic        rf_we, wb_valid, load_fault;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [63:0] instret;

   int n_assert = 0;
   int n_fail   = 0;

   logic        m_valid, m_we, m_fault;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   logic [63:0] m_instret;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
      .opcode(opcode), .funct3(funct3), .rd(rd), .alu_result(alu_result),
      .read_data(read_data), .pc_plus4(pc_plus4), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .wb_valid(wb_valid), .load_fault(load_fault), .instret(instret)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: what one capture of the current inputs should produce.
   task automatic model_edge();
      int          off;
      int          sh;
      logic [31:0] b, h, ld, wd;
      logic        is_load, bad, writes, cap;
      off = int'(alu_result[1:0]);
      b   = (read_data >> (8 * off)) & 32'hFF;
      h   = (read_data >> (16 * (off / 2))) & 32'hFFFF;
      ld  = read_data;
      bad = 1'b0;
      case (funct3)
         3'd0: ld = (b >= 32'h80) ? b - 32'h100 : b;
         3'd4: ld = b;
         3'd1: begin ld = (h >= 32'h8000) ? h - 32'h10000 : h; bad = (off % 2) != 0; end
         3'd5: begin ld = h; bad = (off % 2) != 0; end
         3'd2: bad = off != 0;
         default: bad = 1'b1;
      endcase
      is_load = (opcode == 7'h03);
      writes  = 1'b1;
      wd      = alu_result;
      if (is_load) wd = ld;
      else if (opcode == 7'h6F || opcode == 7'h67) wd = pc_plus4;
      else if (!(opcode == 7'h33 || opcode == 7'h13 || opcode == 7'h37 || opcode == 7'h17))
         writes = 1'b0;
      cap = in_valid && !flush;
      sh  = 0;
      if (!stall) begin
         m_valid = cap;
         m_fault = cap && is_load && bad;
         m_we    = cap && writes && !(is_load && bad) && rd != 0;
         m_waddr = rd;
         m_wdata = wd;
         if (cap) m_instret = m_instret + 64'd1;
      end else if (flush) begin
         m_valid = 1'b0;
         m_we    = 1'b0;
         m_fault = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_we = 0; m_fault = 0; m_waddr = 0; m_wdata = 0; m_instret = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".wb_valid"},   64'(wb_valid),   64'(m_valid));
      chk({tag, ".rf_we"},      64'(rf_we),      64'(m_we));
      chk({tag, ".load_fault"}, 64'(load_fault), 64'(m_fault));
      chk({tag, ".instret"},    instret,         m_instret);
      if (m_we) begin
         chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(m_waddr));
         chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(m_wdata));
      end
   endtask

   task automatic drive(input logic v, input logic st, input logic fl, input logic [6:0] op,
                        input logic [2:0] f3, input logic [4:0] r, input logic [31:0] alu,
                        input logic [31:0] rdat, input logic [31:0] pc);
      in_valid = v; stall = st; flush = fl; opcode = op; funct3 = f3; rd = r;
      alu_result = alu; read_data = rdat; pc_plus4 = pc;
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   localparam logic [6:0] LOAD = 7'h03, JAL = 7'h6F, ADD = 7'h33;

   logic [31:0] lb_exp  [4] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
   logic [31:0] lbu_exp [4] = '{32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080};
   logic [6:0]  ops     [9] = '{7'h03, 7'h6F, 7'h67, 7'h33, 7'h13, 7'h37, 7'h17, 7'h23, 7'h63};
   logic [63:0] snap;

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 7'h0, 3'h0, 5'd0, 32'h0, 32'h0, 32'h0);
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // LB / LBU across byte offsets
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, LOAD, 3'b000, 5'd3, 32'h2000 + 32'(i), 32'h80FF_7F01, 32'h0);
         step("lb");
         chk("lb_const", 64'(rf_wdata), 64'(lb_exp[i]));
         drive(1, 0, 0, LOAD, 3'b100, 5'd4, 32'h2000 + 32'(i), 32'h80FF_7F01, 32'h0);
         step("lbu");
         chk("lbu_const", 64'(rf_wdata), 64'(lbu_exp[i]));
      end

      // LH misaligned, then aligned upper half
      snap = instret;
      drive(1, 0, 0, LOAD, 3'b001, 5'd6, 32'h1001, 32'h8000_1234, 32'h0);
      step("lh_mis");
      chk("lh_mis_fault", 64'(load_fault), 64'd1);
      chk("lh_mis_we", 64'(rf_we), 64'd0);
      chk("lh_mis_cnt", instret, snap + 64'd1);
      drive(1, 0, 0, LOAD, 3'b001, 5'd6, 32'h1002, 32'h8000_1234, 32'h0);
      step("lh_ok");
      chk("lh_ok_data", 64'(rf_wdata), 64'hFFFF8000);
      drive(1, 0, 0, LOAD, 3'b010, 5'd7, 32'h1002, 32'h8000_1234, 32'h0);
      step("lw_mis");
      drive(1, 0, 0, LOAD, 3'b110, 5'd7, 32'h1000, 32'h8000_1234, 32'h0);
      step("ld_illegal");

      // JAL rd=0 first, then rd=1 (leaves rf_we high for the reset check)
      snap = instret;
      drive(1, 0, 0, JAL, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0000_0104);
      step("jal_x0");
      chk("jal_x0_we", 64'(rf_we), 64'd0);
      chk("jal_x0_cnt", instret, snap + 64'd1);
      drive(1, 0, 0, JAL, 3'b000, 5'd1, 32'h0, 32'h0, 32'h0000_0104);
      step("jal");
      chk("jal_data", 64'(rf_wdata), 64'h104);

      // asynchronous reset between edges
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_we", 64'(rf_we), 64'd0);
      chk("arst_waddr", 64'(rf_waddr), 64'd0);
      chk("arst_wdata", 64'(rf_wdata), 64'd0);
      check_all("arst");
      @(negedge clk);
      rst_n = 1'b1;

      // capture ADD then stall 3 cycles, then stall+flush
      drive(1, 0, 0, ADD, 3'b000, 5'd5, 32'hDEAD_BEEF, 32'h0, 32'h0);
      step("add");
      snap = instret;
      drive(1, 1, 0, ADD, 3'b000, 5'd9, 32'h1234_5678, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step("stall");
         chk("stall_data", 64'(rf_wdata), 64'hDEADBEEF);
      end
      chk("stall_cnt", instret, snap);
      drive(1, 1, 1, ADD, 3'b000, 5'd9, 32'h1234_5678, 32'h0, 32'h0);
      step("stall_flush");
      chk("sf_valid", 64'(wb_valid), 64'd0);
      chk("sf_cnt", instret, snap);

      // reset while stalled discards the held instruction
      drive(1, 0, 0, ADD, 3'b000, 5'd8, 32'h55, 32'h0, 32'h0);
      step("add2");
      drive(1, 1, 0, ADD, 3'b000, 5'd8, 32'h66, 32'h0, 32'h0);
      step("stall2");
      #3 rst_n = 1'b0;
      #1 model_reset();
      check_all("arst_stall");
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 1, 0, ADD, 3'b000, 5'd8, 32'h66, 32'h0, 32'h0);
      step("post_rst_stall");

      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
               ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)],
               3'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
         step("rand");
      end

      // counter wrap
      drive(0, 0, 0, ADD, 3'b000, 5'd2, 32'h0, 32'h0, 32'h0);
      step("idle");
      force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 release dut.r_instret;
      m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      drive(1, 0, 0, ADD, 3'b000, 5'd2, 32'h1, 32'h0, 32'h0);
      step("wrap0");
      chk("wrap_zero", instret, 64'd0);
      step("wrap1");
      chk("wrap_one", instret, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RV32I pipeline, directly downstream of the memory stage. Captures the memory stage's results in a MEM/WB pipeline register and extracts and sign- or zero-extends load data by funct3 and byte offset. Selects the register-file write value and drives the register-file write port. Also keeps a 64-bit retired-instruction counter and flags misaligned or malformed loads.

## Interface
Parameters:
- none; datapath width fixed at 32 bits, register index at 5 bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  memory-stage slot holds a real instruction
- stall  input  1  hold MEM/WB register contents
- flush  input  1  kill the instruction being captured
- opcode  input  7  instruction opcode from memory stage
- funct3  input  3  load width/sign selector
- rd  input  5  destination register index
- alu_result  input  32  ALU result; for loads, the byte address
- read_data  input  32  word from data memory, valid in the same cycle as alu_result
- pc_plus4  input  32  return address for JAL/JALR
- rf_we  output  1  register-file write enable
- rf_waddr  output  5  register-file write index
- rf_wdata  output  32  register-file write data
- wb_valid  output  1  MEM/WB register holds a live instruction
- load_fault  output  1  the held instruction is a misaligned or illegal-width load
- instret  output  64  count of retired instructions

## Operation
- Capture condition: rising edge with stall=0. Captured valid = in_valid & ~flush. flush has priority over stall: with flush=1, valid clears even if stall=1.
- With stall=1 and flush=0, every register holds, including instret.
- Load extraction uses off = alu_result[1:0]:
  - funct3 000 (LB): sign-extend byte off.
  - funct3 100 (LBU): zero-extend byte off.
  - funct3 001 (LH): sign-extend halfword at off[1].
  - funct3 101 (LHU): zero-extend halfword at off[1].
  - funct3 010 (LW): full word.
- Load faults:
  - LH/LHU with off[0]=1 is misaligned.
  - LW with off!=0 is misaligned.
  - funct3 011, 110 or 111 on a load is an illegal width.
  - Any fault sets load_fault and suppresses the write.
- Write-data selection is computed before the register and registered:
  - 0000011 (load): extracted load data.
  - 1101111 (JAL) / 1100111 (JALR): pc_plus4.
  - 0110011, 0010011, 0110111, 0010111: alu_result.
  - All other opcodes (store, branch, fence, system, unknown): no write.
- rf_we = wb_valid & writes_rd & ~load_fault & (rf_waddr != 0). A write to x0 is never issued.
- rf_wdata and rf_waddr are registered even when rf_we=0; their value is don't-care when rf_we=0.
- instret increments by 1 on each edge where a valid instruction is captured (in_valid=1, flush=0, stall=0), including faulting loads. It wraps 2^64-1 -> 0.

## Timing
- Latency: one cycle from input edge to outputs.
- rf_we/rf_wdata are registered outputs, so they are usable by the hazard unit for forwarding in the cycle they are asserted.
- Reset (asynchronous, any time):
  - rf_we=0, rf_waddr=0, rf_wdata=0, wb_valid=0, load_fault=0, instret=0, immediately.
  - Reset mid-stall discards the held instruction.
- Release of rst_n is sampled synchronously; the first capture is on the first edge with rst_n=1.
- Stall holding a valid instruction keeps rf_we asserted for multiple cycles. A repeated identical write is permitted, and instret counts the instruction once.
- Simultaneous stall=1, flush=1: wb_valid=0 next cycle, instret unchanged.

## Test plan
- LB/LBU: read_data=32'h80FF_7F01, alu_result offsets 0..3 -> LB gives 00000001, 0000007F, FFFFFFFF, FFFFFF80. LBU gives 01, 7F, FF, 80 zero-extended, each one cycle later.
- LH/LW misalign: LH at alu_result=32'h1001 -> load_fault=1, rf_we=0, instret+1. LH at 32'h1002 with read_data=32'h8000_1234 -> rf_wdata=FFFF8000.
- JAL rd=1 with pc_plus4=32'h0000_0104 -> rf_we=1, rf_waddr=1, rf_wdata=00000104. Same instruction with rd=0 -> rf_we=0, instret+1.
- Stall/flush: capture ADD rd=5, then stall 3 cycles -> outputs held, instret+1 total. stall=1 with flush=1 -> wb_valid=0.
- Reset mid-operation: assert rst_n=0 between edges while rf_we=1 -> all outputs 0 without a clock edge.
- Counter wrap: force instret near 2^64-1, retire two instructions -> 0, then 1.
